// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared state type and lane/width helpers for param_sram_*  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Full word width for a given lane count and lane width.
  function automatic int data_width(input int lanes, input int lane_w);
    return lanes * lane_w;
  endfunction

  // Lowest bit of a lane inside a word.
  function automatic int lane_slice(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_sram_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_sram_core : lane-split storage, masked write, registered read  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module param_sram_core
  import mem_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 10,
  parameter  int LANES  = 16,
  parameter  int LANE_W = 132,
  localparam int DATA_W = data_width(LANES, LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  wmask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic in_range;
  assign in_range = {1'b0, addr} < DEPTH_X;

  // One array per lane keeps each masked write a plain whole-word store.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && in_range && wmask[g])
        mem[addr] <= wdata[lane_slice(g, LANE_W) +: LANE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        rd_q <= '0;
      else if (re)
        rd_q <= in_range ? mem[addr] : '0;
    end

    assign rdata[lane_slice(g, LANE_W) +: LANE_W] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/param_sram_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_sram_ctl : SRAM wrapper with zero-init sequencer, ready/valid, |
// | read-data hold, out-of-range flagging and 1/2-cycle read latency     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module param_sram_ctl
  import mem_pkg::*;
#(
  parameter  int DEPTH         = 1024,
  parameter  int ADDR_W        = 10,
  parameter  int LANES         = 16,
  parameter  int LANE_W        = 132,
  parameter  int READ_LAT      = 1,
  parameter  int INIT_ON_RESET = 1,
  localparam int DATA_W        = data_width(LANES, LANE_W)
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic              RW0_clear,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic [LANES-1:0]  RW0_wmask,
  input  logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_ready,
  output logic              RW0_rvalid,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_oor
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic              accept, in_range;
  logic              core_we, core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [LANES-1:0]  core_wmask;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              v1, o1;

  assign RW0_ready = (state == ST_RUN) && !RW0_clear;
  assign accept    = RW0_en && RW0_ready;
  assign in_range  = {1'b0, RW0_addr} < DEPTH_X;

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    core_we    = accept && RW0_wmode;
    core_re    = accept && !RW0_wmode;
    core_addr  = RW0_addr;
    core_wmask = RW0_wmask;
    core_wdata = RW0_wdata;
    case (state)
      ST_CLEAR: begin
        core_we    = 1'b1;
        core_addr  = cnt;
        core_wmask = '1;
        core_wdata = '0;
        if (cnt == LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (RW0_clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  param_sram_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_core (
    .clk   (RW0_clk),
    .rst_n (RW0_rst_n),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .wmask (core_wmask),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Out-of-range is flagged for reads and writes alike, on the read timing.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      v1 <= 1'b0;
      o1 <= 1'b0;
    end else begin
      v1 <= accept && !RW0_wmode;
      o1 <= accept && !in_range;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              v2, o2;
    logic [DATA_W-1:0] rd2;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        v2  <= 1'b0;
        o2  <= 1'b0;
        rd2 <= '0;
      end else begin
        v2 <= v1;
        o2 <= o1;
        if (v1)
          rd2 <= core_rdata;
      end
    end

    assign RW0_rvalid = v2;
    assign RW0_oor    = o2;
    assign RW0_rdata  = rd2;
  end else begin : g_lat1
    assign RW0_rvalid = v1;
    assign RW0_oor    = o1;
    assign RW0_rdata  = core_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_param_sram_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_sram_ctl : checks READ_LAT=1 and READ_LAT=2 instances side  |
// | by side against a word-level memory model. Revision: 1.0             |
// +----------------------------------------------------------------------+
module tb_param_sram_ctl;

  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic        wmode = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;

  logic        ready1, rv1, oor1, ready2, rv2, oor2;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_sram_ctl #(.DEPTH(12), .ADDR_W(4), .LANES(4), .LANE_W(8), .READ_LAT(1), .INIT_ON_RESET(1)) u_dut1 (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_clear(clear), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_ready(ready1), .RW0_rvalid(rv1), .RW0_rdata(rd1), .RW0_oor(oor1)
  );

  param_sram_ctl #(.DEPTH(12), .ADDR_W(4), .LANES(4), .LANE_W(8), .READ_LAT(2), .INIT_ON_RESET(1)) u_dut2 (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_clear(clear), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_ready(ready2), .RW0_rvalid(rv2), .RW0_rdata(rd2), .RW0_oor(oor2)
  );

  // Model: memory contents, remaining clear cycles, and per-latency
  // response slots keyed by the cycle at which the response must appear.
  logic [31:0] mdl [DEPTH];
  int          busy;
  int          cyc = 0;
  bit          ev_rv  [2][16];
  bit          ev_oor [2][16];
  logic [31:0] ev_data[2][16];
  logic [31:0] hold   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sched(input bit rv, input logic [31:0] d, input bit o);
    for (int k = 0; k < 2; k++) begin
      ev_rv[k][(cyc + k + 1) % 16]   = rv;
      ev_data[k][(cyc + k + 1) % 16] = d;
      ev_oor[k][(cyc + k + 1) % 16]  = o;
    end
  endtask

  task automatic verify_outputs();
    int idx;
    idx = cyc % 16;
    for (int k = 0; k < 2; k++) begin
      if (ev_rv[k][idx]) hold[k] = ev_data[k][idx];
      check($sformatf("rvalid_lat%0d@%0d", k + 1, cyc), 32'(k == 0 ? rv1 : rv2), 32'(ev_rv[k][idx]));
      check($sformatf("oor_lat%0d@%0d", k + 1, cyc), 32'(k == 0 ? oor1 : oor2), 32'(ev_oor[k][idx]));
      check($sformatf("rdata_lat%0d@%0d", k + 1, cyc), k == 0 ? rd1 : rd2, hold[k]);
      ev_rv[k][idx]  = 1'b0;
      ev_oor[k][idx] = 1'b0;
    end
  endtask

  task automatic step(input bit en_i, input bit wm_i, input logic [3:0] a,
                      input logic [3:0] m, input logic [31:0] d, input bit clr);
    bit exp_ready;
    en = en_i; wmode = wm_i; addr = a; wmask = m; wdata = d; clear = clr;
    #1;
    exp_ready = (busy == 0) && !clr;
    check($sformatf("ready_lat1@%0d", cyc), 32'(ready1), 32'(exp_ready));
    check($sformatf("ready_lat2@%0d", cyc), 32'(ready2), 32'(exp_ready));
    if (busy > 0) begin
      busy--;
    end else if (clr) begin
      busy = DEPTH;
      for (int w = 0; w < DEPTH; w++) mdl[w] = '0;
    end else if (en_i) begin
      if (wm_i) begin
        if (a < DEPTH)
          for (int l = 0; l < 4; l++)
            if (m[l]) mdl[a][l*8 +: 8] = d[l*8 +: 8];
        sched(1'b0, '0, a >= DEPTH);
      end else begin
        sched(1'b1, (a < DEPTH) ? mdl[a] : 32'h0, a >= DEPTH);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    verify_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1'b1, 1'b1, a, m, d, 1'b0);
  endtask

  task automatic do_reset(input int n);
    en = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_rdata_lat1", rd1, 32'h0);
    check("reset_rdata_lat2", rd2, 32'h0);
    check("reset_rvalid", {30'b0, rv1, rv2}, 32'h0);
    check("reset_oor", {30'b0, oor1, oor2}, 32'h0);
    check("reset_ready", {30'b0, ready1, ready2}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      hold[k] = '0;
      for (int s = 0; s < 16; s++) begin
        ev_rv[k][s] = 1'b0; ev_oor[k][s] = 1'b0; ev_data[k][s] = '0;
      end
    end
    busy = DEPTH;
    for (int w = 0; w < DEPTH; w++) mdl[w] = '0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset(3);
    // Power-up clear, then every word reads zero.
    idle(DEPTH);
    idle(1);
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    idle(2);

    // Masked writes.
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd(4'd5);
    idle(2);
    check("masked_write_1", rd2, 32'h00BB00DD);
    wr(4'd5, 32'h11223344, 4'b1000);
    rd(4'd5);
    idle(2);
    check("masked_write_2", rd1, 32'h11BB00DD);

    // Pipelined reads and hold.
    wr(4'd3, 32'h03030303, 4'hF);
    wr(4'd4, 32'h04040404, 4'hF);
    rd(4'd3); rd(4'd4); rd(4'd5);
    idle(10);
    check("hold_lat2", rd2, 32'h11BB00DD);

    // Clear collision: read before clear completes, write on clear is dropped.
    wr(4'd2, 32'h55667788, 4'hF);
    rd(4'd2);
    step(1'b1, 1'b1, 4'd2, 4'hF, 32'hDEADBEEF, 1'b1);
    idle(DEPTH);
    check("clear_hold_lat1", rd1, 32'h55667788);
    rd(4'd2);
    idle(2);
    check("clear_addr2_zero", rd1, 32'h0);

    // Out-of-range.
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'h10101010 * 32'(i + 1), 4'hF);
    rd(4'd13);
    wr(4'd14, 32'hFFFFFFFF, 4'hF);
    idle(2);
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    idle(2);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           4'($urandom), $urandom, $urandom_range(0, 39) == 0);
    end
    idle(DEPTH + 2);

    // Reset in the middle of a clear sequence.
    wr(4'd7, 32'hCAFEF00D, 4'hF);
    rd(4'd7);
    idle(1);
    step(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1);
    idle(6);
    do_reset(3);
    idle(DEPTH);
    idle(1);
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
